// File: rtl/regs_wr_arbiter_if.sv
// Requester-side bundle for the register-file write arbiter.
// The requester drives valid/addr/data, and the arbiter answers with a per-requester ready.
interface regs_wr_arbiter_if #(
  parameter int NREQ = 3,
  parameter int DW   = 8
);
  logic [NREQ-1:0]               req_valid;
  logic [NREQ-1:0][1:0]          req_addr;
  logic [NREQ-1:0][DW-1:0]       req_data;
  logic [NREQ-1:0]               req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/regs_wr_arbiter.sv
// Round-robin arbiter for the register file's single write port, plus a one-entry write stage.
// The block also keeps a saturating counter of contended cycles for performance debug.
module regs_wr_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 8,
  parameter int NREG = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_hold_i,
  regs_wr_arbiter_if.slave           req_if,
  output logic [NREG-1:0][DW-1:0]    regs_in_o,
  output logic [NREG-1:0]            write_en_o,
  output logic [NREG-1:0]            pending_o,
  output logic [7:0]                 conflict_cnt_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]  last_q, last_d;
  logic           stgValid_q, stgValid_d;
  logic [1:0]     stgAddr_q, stgAddr_d;
  logic [DW-1:0]  stgData_q, stgData_d;
  logic [7:0]     conflictCnt_q, conflictCnt_d;

  logic           grantAny;
  logic [IW-1:0]  grantIdx;
  logic           transfer;
  logic           contended;

  // The search starts one past the last winner, so the previous winner has the lowest priority.
  always_comb begin
    int cand;
    grantAny = 1'b0;
    grantIdx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_q) + k) % NREQ;
      if (!grantAny && req_if.req_valid[cand]) begin
        grantAny = 1'b1;
        grantIdx = IW'(cand);
      end
    end
  end

  assign transfer = grantAny && !wr_hold_i && rst_n;

  always_comb begin
    req_if.req_ready = '0;
    if (transfer) begin
      req_if.req_ready = NREQ'(1) << grantIdx;
    end
  end

  assign contended = !wr_hold_i && ($countones(req_if.req_valid) >= 2);

  always_comb begin
    last_d        = last_q;
    stgValid_d    = 1'b0;
    stgAddr_d     = stgAddr_q;
    stgData_d     = stgData_q;
    conflictCnt_d = conflictCnt_q;
    if (transfer) begin
      last_d     = grantIdx;
      stgValid_d = 1'b1;
      stgAddr_d  = req_if.req_addr[grantIdx];
      stgData_d  = req_if.req_data[grantIdx];
    end
    if (contended && conflictCnt_q != 8'hFF) begin
      conflictCnt_d = conflictCnt_q + 8'd1;
    end
  end

  // Resetting last to NREQ-1 gives requester 0 first priority after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q        <= IW'(NREQ - 1);
      stgValid_q    <= 1'b0;
      stgAddr_q     <= '0;
      stgData_q     <= '0;
      conflictCnt_q <= '0;
    end else begin
      last_q        <= last_d;
      stgValid_q    <= stgValid_d;
      stgAddr_q     <= stgAddr_d;
      stgData_q     <= stgData_d;
      conflictCnt_q <= conflictCnt_d;
    end
  end

  always_comb begin
    write_en_o = '0;
    regs_in_o  = '0;
    if (stgValid_q) begin
      write_en_o = NREG'(1) << stgAddr_q;
      for (int k = 0; k < NREG; k++) begin
        regs_in_o[k] = stgData_q;
      end
    end
  end

  assign pending_o      = write_en_o;
  assign conflict_cnt_o = conflictCnt_q;

endmodule

// File: tb/tb_regs_wr_arbiter.sv
// Directed bench for regs_wr_arbiter, with a behavioural register file capturing the write port.
// Inputs are driven on the negedge. The combinational ready is sampled there, and stage outputs are sampled 1ns after the posedge.
module tb_regs_wr_arbiter;

  logic                 clk;
  logic                 rst_n;
  logic                 wr_hold;
  logic [3:0][7:0]      regs_in;
  logic [3:0]           write_en;
  logic [3:0]           pending;
  logic [7:0]           conflict_cnt;
  logic [7:0]           regModel [4];

  int vectors;
  int miscompares;

  regs_wr_arbiter_if #(.NREQ(3), .DW(8)) bus ();

  regs_wr_arbiter #(.NREQ(3), .DW(8), .NREG(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_hold_i      (wr_hold),
    .req_if         (bus),
    .regs_in_o      (regs_in),
    .write_en_o     (write_en),
    .pending_o      (pending),
    .conflict_cnt_o (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The external register file captures whichever lane is enabled.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (write_en[k]) regModel[k] <= regs_in[k];
    end
  end

  task automatic clearInputs();
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    wr_hold       = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    clearInputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clearInputs();
    bus.req_valid = 3'b111;
    #1;
    vectors++;
    if (bus.req_ready !== 3'b000) begin
      $display("[TB] FAIL reset_ready got=%b want=000", bus.req_ready);
      miscompares++;
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (write_en !== 4'b0000 || pending !== 4'b0000 || regs_in !== 32'h0) begin
      $display("[TB] FAIL reset_outputs write_en=%b pending=%b regs_in=%h want all 0",
               write_en, pending, regs_in);
      miscompares++;
    end
    vectors++;
    if (conflict_cnt !== 8'd0) begin
      $display("[TB] FAIL reset_conflict got=%0d want=0", conflict_cnt);
      miscompares++;
    end
    @(negedge clk);
    bus.req_valid = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (write_en !== 4'b0000 || conflict_cnt !== 8'd0) begin
      $display("[TB] FAIL idle_outputs write_en=%b cnt=%0d want 0000/0", write_en, conflict_cnt);
      miscompares++;
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    bus.req_valid   = 3'b001;
    bus.req_addr[0] = 2'd2;
    bus.req_data[0] = 8'h5A;
    #1;
    vectors++;
    if (bus.req_ready !== 3'b001) begin
      $display("[TB] FAIL single_ready got=%b want=001", bus.req_ready);
      miscompares++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    vectors++;
    if (write_en !== 4'b0100 || pending !== 4'b0100 || regs_in[2] !== 8'h5A) begin
      $display("[TB] FAIL single_write write_en=%b pending=%b data=%h want 0100/0100/5a",
               write_en, pending, regs_in[2]);
      miscompares++;
    end
    @(posedge clk);
    #1;
    vectors++;
    if (write_en !== 4'b0000 || pending !== 4'b0000) begin
      $display("[TB] FAIL single_drain write_en=%b pending=%b want 0000", write_en, pending);
      miscompares++;
    end
    vectors++;
    if (regModel[2] !== 8'h5A) begin
      $display("[TB] FAIL single_commit reg_c=%h want=5a", regModel[2]);
      miscompares++;
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] expReady;
    logic [3:0] expWen;
    doReset();
    @(negedge clk);
    bus.req_valid = 3'b111;
    for (int i = 0; i < 3; i++) begin
      bus.req_addr[i] = 2'(i);
      bus.req_data[i] = 8'h10 + 8'(i);
    end
    for (int i = 0; i < 6; i++) begin
      expReady = 3'b001 << (i % 3);
      expWen   = 4'b0001 << (i % 3);
      #1;
      vectors++;
      if (bus.req_ready !== expReady) begin
        $display("[TB] FAIL rr_grant%0d got=%b want=%b", i, bus.req_ready, expReady);
        miscompares++;
      end
      @(posedge clk);
      #1;
      if (i == 5) bus.req_valid = '0;
      vectors++;
      if (write_en !== expWen || regs_in[0] !== 8'h10 + 8'(i % 3)) begin
        $display("[TB] FAIL rr_write%0d write_en=%b data=%h want %b/%h",
                 i, write_en, regs_in[0], expWen, 8'h10 + 8'(i % 3));
        miscompares++;
      end
      @(negedge clk);
    end
    vectors++;
    if (conflict_cnt !== 8'd6) begin
      $display("[TB] FAIL rr_conflict got=%0d want=6", conflict_cnt);
      miscompares++;
    end
  endtask

  task automatic test_hold();
    doReset();
    @(negedge clk);
    wr_hold         = 1'b1;
    bus.req_valid   = 3'b010;
    bus.req_addr[1] = 2'd3;
    bus.req_data[1] = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (bus.req_ready !== 3'b000) begin
        $display("[TB] FAIL hold_ready%0d got=%b want=000", i, bus.req_ready);
        miscompares++;
      end
      @(posedge clk);
      #1;
      vectors++;
      if (write_en !== 4'b0000) begin
        $display("[TB] FAIL hold_wen%0d got=%b want=0000", i, write_en);
        miscompares++;
      end
      @(negedge clk);
    end
    wr_hold = 1'b0;
    #1;
    vectors++;
    if (bus.req_ready !== 3'b010) begin
      $display("[TB] FAIL hold_release_ready got=%b want=010", bus.req_ready);
      miscompares++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    vectors++;
    if (write_en !== 4'b1000 || regs_in[3] !== 8'hC3) begin
      $display("[TB] FAIL hold_write write_en=%b data=%h want 1000/c3", write_en, regs_in[3]);
      miscompares++;
    end
    // Two valids under hold are not contention.
    @(negedge clk);
    wr_hold       = 1'b1;
    bus.req_valid = 3'b011;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (conflict_cnt !== 8'd0) begin
      $display("[TB] FAIL hold_conflict got=%0d want=0", conflict_cnt);
      miscompares++;
    end
    clearInputs();
  endtask

  task automatic test_back_to_back();
    doReset();
    @(negedge clk);
    bus.req_valid   = 3'b011;
    bus.req_addr[0] = 2'd0;
    bus.req_data[0] = 8'h11;
    bus.req_addr[1] = 2'd0;
    bus.req_data[1] = 8'h22;
    #1;
    vectors++;
    if (bus.req_ready !== 3'b001) begin
      $display("[TB] FAIL b2b_first_ready got=%b want=001", bus.req_ready);
      miscompares++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 3'b010;
    vectors++;
    if (write_en !== 4'b0001 || regs_in[0] !== 8'h11) begin
      $display("[TB] FAIL b2b_first_write write_en=%b data=%h want 0001/11", write_en, regs_in[0]);
      miscompares++;
    end
    vectors++;
    if (bus.req_ready !== 3'b010) begin
      $display("[TB] FAIL b2b_second_ready got=%b want=010", bus.req_ready);
      miscompares++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    vectors++;
    if (write_en !== 4'b0001 || regs_in[0] !== 8'h22) begin
      $display("[TB] FAIL b2b_second_write write_en=%b data=%h want 0001/22", write_en, regs_in[0]);
      miscompares++;
    end
    @(posedge clk);
    #1;
    vectors++;
    if (regModel[0] !== 8'h22 || conflict_cnt !== 8'd1) begin
      $display("[TB] FAIL b2b_final reg_a=%h cnt=%0d want 22/1", regModel[0], conflict_cnt);
      miscompares++;
    end
  endtask

  task automatic test_saturation();
    logic [2:0] expReady;
    int         expCnt;
    doReset();
    @(negedge clk);
    bus.req_valid   = 3'b011;
    bus.req_addr[0] = 2'd1;
    bus.req_addr[1] = 2'd2;
    for (int i = 0; i < 300; i++) begin
      expReady = (i % 2 == 0) ? 3'b001 : 3'b010;
      expCnt   = (i + 1 > 255) ? 255 : i + 1;
      #1;
      vectors++;
      if (bus.req_ready !== expReady) begin
        $display("[TB] FAIL sat_grant%0d got=%b want=%b", i, bus.req_ready, expReady);
        miscompares++;
      end
      @(posedge clk);
      #1;
      vectors++;
      if (conflict_cnt !== 8'(expCnt)) begin
        $display("[TB] FAIL sat_count%0d got=%0d want=%0d", i, conflict_cnt, expCnt);
        miscompares++;
      end
      @(negedge clk);
    end
    clearInputs();
  endtask

  task automatic test_async_reset();
    logic [7:0] regBefore;
    doReset();
    regBefore = regModel[1];
    @(negedge clk);
    bus.req_valid   = 3'b001;
    bus.req_addr[0] = 2'd1;
    bus.req_data[0] = (regBefore == 8'h77) ? 8'h78 : 8'h77;
    @(posedge clk);
    #1;
    vectors++;
    if (write_en !== 4'b0010) begin
      $display("[TB] FAIL arst_staged write_en=%b want=0010", write_en);
      miscompares++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (write_en !== 4'b0000 || pending !== 4'b0000 || regs_in !== 32'h0) begin
      $display("[TB] FAIL arst_drop write_en=%b pending=%b regs_in=%h want all 0",
               write_en, pending, regs_in);
      miscompares++;
    end
    vectors++;
    if (bus.req_ready !== 3'b000) begin
      $display("[TB] FAIL arst_ready got=%b want=000", bus.req_ready);
      miscompares++;
    end
    @(posedge clk);
    #1;
    vectors++;
    if (regModel[1] !== regBefore) begin
      $display("[TB] FAIL arst_discard reg_b=%h want=%h", regModel[1], regBefore);
      miscompares++;
    end
    @(negedge clk);
    bus.req_valid = 3'b111;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.req_ready !== 3'b001) begin
      $display("[TB] FAIL arst_priority got=%b want=001", bus.req_ready);
      miscompares++;
    end
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the test sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int k = 0; k < 4; k++) regModel[k] = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regs_wr_arbiter.md
# regs_wr_arbiter

Round-robin arbiter and write sequencer for the 4 x 8-bit register file's single write port. Up to three requesters (ALU result, load return, immediate move) compete for that port. Each requester uses a valid/ready handshake, and the block grants one per cycle. The granted write is registered into a one-entry write stage that drives the register file's `regs_in` and one-hot `write_en` on the following cycle. The block also keeps a saturating contention counter for performance debug.

## Interface
Parameters:
- `NREQ`, 3, number of requesters (2..4)
- `DW`, 8, data width; equals the register width
- `NREG`, 4, number of registers; equals the `write_en` width

Ports:
- `clk`  in  1  single clock; all state updates on posedge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `wr_hold`  in  1  when high, no new grants are issued; the write stage still drains
- `req_valid`  in  [NREQ]  requester i has a write pending
- `req_addr`  in  [NREQ][2]  target register index (0=a, 1=b, 2=c, 3=d)
- `req_data`  in  [NREQ][DW]  write data
- `req_ready`  out  [NREQ]  grant for the current cycle; combinational, one-hot or zero
- `regs_in`  out  [NREG][DW]  to register file; stage data replicated on all lanes
- `write_en`  out  [NREG]  to register file; one-hot or zero, registered
- `pending`  out  [NREG]  bit k is high while a write to register k is in the stage
- `conflict_cnt`  out  [8]  saturating count of contended cycles

## Operation
- Transfer: requester i transfers in a cycle where `req_valid[i] && req_ready[i]`.
  - Requesters hold valid, addr and data stable until ready.
  - Valid must not drop before the transfer.
- Grant rule:
  - No grant while `wr_hold` is high or no valid is asserted.
  - Otherwise exactly one `req_ready` is high.
  - The winner is the first valid requester searched from `last+1` upward, wrapping modulo NREQ.
- Round-robin pointer `last`:
  - Updates to the winner index on a transfer only.
  - Unchanged in idle and hold cycles.
- Write stage:
  - A transfer loads `{stg_valid=1, stg_addr, stg_data}`.
  - A cycle without a transfer loads `stg_valid=0`.
  - The register file accepts every cycle, so the stage never back-pressures.
- Outputs from the stage:
  - `write_en = stg_valid ? (1 << stg_addr) : 0`.
  - `regs_in[k] = stg_valid ? stg_data : 0` for all k.
  - `pending = write_en`.
- Back-to-back writes to the same register are allowed. Commit order equals grant order.
- `conflict_cnt`:
  - Increments by 1 in every cycle where `wr_hold` is low and two or more `req_valid` are high.
  - Saturates at 255.
  - Hold cycles are not counted.
- `NREQ` below 4: `req_*` indices at or above NREQ do not exist.

## Timing
- Reset (`rst_n` low, asynchronous):
  - `stg_valid=0`, `write_en=0`, `regs_in` all 0, `pending=0`.
  - `conflict_cnt=0`, `last=NREQ-1`, so requester 0 has first priority.
  - `req_ready` is forced to 0 while `rst_n` is low.
- Latency: transfer in cycle N puts `write_en` high during cycle N+1. The register file captures at the posedge ending N+1.
  - Register value is visible from cycle N+2.
  - Accept-to-visible latency: 2 edges.
- Throughput: one write per cycle sustained. Three continuous requesters receive grants 0,1,2,0,1,2...
- `wr_hold` rising in cycle N:
  - `req_ready` is 0 in cycle N (combinational).
  - A transfer accepted in N-1 still commits in N.
- Single valid requester: it is granted every cycle regardless of `last`.
- Reset mid-operation: any stage contents are discarded and not written. `write_en` drops immediately (asynchronous).
- `req_valid` with no other valid and `wr_hold` low: `req_ready` is high in the same cycle, with zero wait.

## Test plan
- Reset then idle:
  - Required response: all outputs 0 and `conflict_cnt=0`.
  - Then req0 valid, addr 2, data 0x5A, for 1 cycle: `req_ready=001` in that cycle; `write_en=0100` with `regs_in[2]=0x5A` the next cycle; `pending=0100` for exactly 1 cycle.
- Round-robin fairness:
  - Stimulus: req0, req1 and req2 valid continuously for 6 cycles, each to a distinct address.
  - Required response: grant sequence 0,1,2,0,1,2; `conflict_cnt=6`.
- Hold:
  - Stimulus: req1 valid with `wr_hold` high for 3 cycles, then low.
  - Required response: `req_ready=0` for 3 cycles; grant on the 4th cycle; `write_en` asserted on the 5th; `conflict_cnt` unchanged.
- Same-register back-to-back:
  - Stimulus: req0 writes 0x11 to addr 0, then req1 writes 0x22 to addr 0.
  - Required response: `write_en=0001` for 2 consecutive cycles with data 0x11 then 0x22; final reg_a=0x22.
- Saturation:
  - Stimulus: req0 and req1 valid continuously for 300 cycles.
  - Required response: `conflict_cnt` stops at 255; grants alternate strictly 0,1,0,1...
- Async reset mid-write:
  - Stimulus: assert `rst_n` low while `stg_valid=1`.
  - Required response: `write_en` and `pending` go to 0 without a clock edge; after release, requester 0 wins first among simultaneous valids.
